vgafb_fifo_wrctl: RTL and testbench
===================================

# vgafb_fifo_wrctl

Write-side controller of the framebuffer pixel FIFO. It sits directly upstream of the dual-port pixel RAM and produces the write address, the write enable and a Gray-coded write pointer for the read-clock domain. It synchronises the Gray read pointer coming back from the read domain into `Clk`, and from that pointer it derives full, almost-full, fill level and overflow status. The block has one clock; the read side is a separate block.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: RAM address width. Depth is `DEPTH = 2**ADDR_WIDTH`. Pointers are `ADDR_WIDTH+1` bits.
- `AF_MARGIN`, default 2: `AlmostFull_out` asserts when level ≥ `DEPTH - AF_MARGIN`. Legal range is 1..`DEPTH-1`.

Ports:
- `Clk`, in, 1: write clock. One clock; every register in the block is clocked on its rising edge.
- `Clear_in`, in, 1: reset. Synchronous, active-high.
- `WrReq_in`, in, 1: push request from the pixel producer.
- `RdPtrGray_in`, in, `ADDR_WIDTH+1`: Gray read pointer from the read domain. Asynchronous to `Clk`.
- `WrEn_out`, out, 1: RAM write strobe.
- `WrAddr_out`, out, `ADDR_WIDTH`: RAM write address.
- `WrPtrGray_out`, out, `ADDR_WIDTH+1`: registered Gray write pointer, sent to the read domain.
- `Full_out`, out, 1: FIFO full.
- `AlmostFull_out`, out, 1: level ≥ `DEPTH - AF_MARGIN`.
- `WrLevel_out`, out, `ADDR_WIDTH+1`: conservative fill level.
- `Overflow_out`, out, 1: sticky flag, set when a push is requested while full.

## Operation
- Internal state:
  - binary write pointer `wbin` and Gray write pointer `wgray`, both `ADDR_WIDTH+1` bits;
  - two-stage synchroniser `rq1` → `rq2` on `RdPtrGray_in`;
  - registered flag, level and overflow registers.
- `WrEn_out = WrReq_in & ~Full_out & ~Clear_in`. This is combinational and is the only combinational output.
- `WrAddr_out = wbin[ADDR_WIDTH-1:0]`.
- On an accepted write:
  - `wbin_next = wbin + 1`, modulo `2**(ADDR_WIDTH+1)`, so it wraps naturally;
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- `WrPtrGray_out = wgray`. It is a register and changes exactly one bit per accepted write.
- Full test, evaluated on `wgray_next` against `rq2`: the top two bits of `wgray_next` equal the inverted top two bits of `rq2`, and all remaining bits are equal.
- Level:
  - `rbin` is the Gray-to-binary conversion of `rq2`: an XOR prefix from the MSB down.
  - `WrLevel_out <= wbin_next - rbin`, unsigned, `ADDR_WIDTH+1` bits, range 0..`DEPTH`.
- `AlmostFull_out <=` the registered comparison of the new level against `DEPTH - AF_MARGIN`.
- `Overflow_out` sets when `WrReq_in & Full_out`. It holds until `Clear_in`. The rejected push is dropped; pointers do not move.
- Clear behaviour:
  - `Clear_in` is asserted together with the read-side clear. The system guarantees this.
  - A clear mid-stream discards all contents.
  - `Clear_in` has priority over `WrReq_in` in the same cycle.

## Timing
- Reset (`Clear_in` high at a rising edge): the following are all 0 after that edge:
  - `wbin`, `wgray`, `rq1`, `rq2`;
  - `Full_out`, `AlmostFull_out`, `WrLevel_out`, `Overflow_out`.
  - `WrAddr_out` = 0 and `WrPtrGray_out` = 0.
- Write latency:
  - A request accepted in cycle t writes the RAM at the edge that ends cycle t, at `WrAddr_out`.
  - `WrAddr_out`, `WrPtrGray_out`, `Full_out`, `WrLevel_out` and `AlmostFull_out` reflect that write from cycle t+1.
  - The writer therefore sees `Full_out` with no lag, and back-to-back writes never overrun.
- Read-pointer lag:
  - A change on `RdPtrGray_in` reaches `rq2` after two edges.
  - Flags and level reflect it after the third edge.
  - Flags are pessimistic only: full may persist up to 3 cycles after space frees. Full is never deasserted early.
- Full and a write in the same cycle: `WrEn_out` = 0, `Overflow_out` = 1 from the next cycle.

## Structure
- Shared package `vgafb_pkg`:
  - default `ADDR_WIDTH` and `AF_MARGIN` constants;
  - `bin2gray` and `gray2bin` functions, parameterised by width. The read-side controller reuses these.
- One sub-module, `vgafb_ptr_sync`: a 2-FF Gray-pointer synchroniser, width-parameterised, with synchronous clear. The read side reuses it to bring `WrPtrGray_out` into its own clock.

## Test plan
- Fill (`ADDR_WIDTH`=4, `RdPtrGray_in`=0, `WrReq_in` high 17 cycles):
  - `WrAddr_out` steps 0..15;
  - `Full_out` = 1 and `WrLevel_out` = 16 after the 16th accept;
  - the 17th request gives `WrEn_out` = 0 and `Overflow_out` = 1.
- Drain release: from full, set `RdPtrGray_in` = 6 (binary 4).
  - `Full_out` falls and `WrLevel_out` = 12 after exactly the 3rd rising edge.
  - `AlmostFull_out` (`AF_MARGIN`=2) = 0 at the same edge.
- Wrap: 40 writes, with the read pointer driven to trail by ≤ 8.
  - `WrAddr_out` wraps 15→0.
  - `WrPtrGray_out` changes exactly one bit per accepted write.
  - The pointer MSB toggles at 16 and 32.
  - `Full_out` is never set.
- Almost-full boundary: with a static read pointer, `AlmostFull_out` rises in the cycle after the 14th accept, not before.
- Clear mid-stream: at level 9 with `Overflow_out` = 1, assert `Clear_in` with `WrReq_in` = 1.
  - `WrEn_out` = 0 during the clear cycle.
  - All outputs are 0 after the edge.
  - The next write uses `WrAddr_out` = 0.

Source files
------------

// File: rtl/vgafb_pkg.sv
// Shared framebuffer FIFO definitions: default geometry and Gray-code helpers.
// Helpers operate on zero-extended 32-bit values, so they serve any pointer width.
package vgafb_pkg;

    localparam int VGAFB_ADDR_WIDTH = 4;
    localparam int VGAFB_AF_MARGIN  = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrower pointers intact.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/vgafb_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into this clock.
// Latency: two edges; no backpressure; synchronous active-high clear.
module vgafb_ptr_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rq1;

    always_ff @(posedge clk) begin
        if (clear) begin
            rq1 <= '0;
            q   <= '0;
        end else begin
            rq1 <= d;
            q   <= rq1;
        end
    end

endmodule

// File: rtl/vgafb_fifo_wrctl.sv
// Write-side controller of the pixel FIFO: RAM write strobe/address, Gray write pointer, flags.
// Latency: write strobe combinational, status registered (one cycle); full blocks pushes, which set sticky overflow.
module vgafb_fifo_wrctl
    import vgafb_pkg::*;
#(
    parameter int ADDR_WIDTH = VGAFB_ADDR_WIDTH,
    parameter int AF_MARGIN  = VGAFB_AF_MARGIN
) (
    input  logic                  Clk,
    input  logic                  Clear_in,
    input  logic                  WrReq_in,
    input  logic [ADDR_WIDTH:0]   RdPtrGray_in,
    output logic                  WrEn_out,
    output logic [ADDR_WIDTH-1:0] WrAddr_out,
    output logic [ADDR_WIDTH:0]   WrPtrGray_out,
    output logic                  Full_out,
    output logic                  AlmostFull_out,
    output logic [ADDR_WIDTH:0]   WrLevel_out,
    output logic                  Overflow_out
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wgray;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          push;

    vgafb_ptr_sync #(.WIDTH(PW)) u_rd_sync (
        .clk   (Clk),
        .clear (Clear_in),
        .d     (RdPtrGray_in),
        .q     (rq2)
    );

    assign push          = WrReq_in & ~Full_out & ~Clear_in;
    assign WrEn_out      = push;
    assign WrAddr_out    = wbin[ADDR_WIDTH-1:0];
    assign WrPtrGray_out = wgray;

    // Status is computed on the post-write pointer so the writer sees full with no lag.
    always_comb begin
        wbin_next  = wbin + PW'(push);
        wgray_next = PW'(bin2gray(32'(wbin_next)));
        rbin       = PW'(gray2bin(32'(rq2)));
        level_next = wbin_next - rbin;
        full_next  = (wgray_next == (rq2 ^ FULL_MASK));
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wbin           <= '0;
            wgray          <= '0;
            Full_out       <= 1'b0;
            AlmostFull_out <= 1'b0;
            WrLevel_out    <= '0;
            Overflow_out   <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wgray          <= wgray_next;
            Full_out       <= full_next;
            AlmostFull_out <= (level_next >= AF_LEVEL);
            WrLevel_out    <= level_next;
            if (WrReq_in && Full_out) begin
                Overflow_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vgafb_fifo_wrctl.sv
// Directed bench for the FIFO write controller: vector table plus wrap and almost-full sequences.
module tb_vgafb_fifo_wrctl;

    logic       clk;
    logic       clear;
    logic       wr_req;
    logic [4:0] rd_gray;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_gray;
    logic       full;
    logic       af;
    logic [4:0] level;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    vgafb_fifo_wrctl #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
        .Clk            (clk),
        .Clear_in       (clear),
        .WrReq_in       (wr_req),
        .RdPtrGray_in   (rd_gray),
        .WrEn_out       (wr_en),
        .WrAddr_out     (wr_addr),
        .WrPtrGray_out  (wr_gray),
        .Full_out       (full),
        .AlmostFull_out (af),
        .WrLevel_out    (level),
        .Overflow_out   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clear;
        logic       wr;
        logic [4:0] rd;
        logic       en;
        logic [3:0] addr_pre;
        logic [3:0] addr;
        logic [4:0] wgray;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] tg(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input logic c, input logic w, input logic [4:0] r, input logic e,
                                input int ap, input int a, input logic [4:0] g, input logic f,
                                input logic al, input int l, input logic o);
        vec_t v;
        v.clear = c; v.wr = w; v.rd = r; v.en = e;
        v.addr_pre = 4'(ap); v.addr = 4'(a); v.wgray = g;
        v.full = f; v.af = al; v.level = 5'(l); v.ovf = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic [4:0] r);
        @(negedge clk);
        clear   = c;
        wr_req  = w;
        rd_gray = r;
    endtask

    task automatic do_clear();
        drive(1'b1, 1'b0, 5'd0);
        @(posedge clk);
        #1;
    endtask

    logic [4:0] prev_gray;

    initial begin
        clear = 1'b1; wr_req = 1'b0; rd_gray = '0;
        do_clear();

        // Clear wins over a simultaneous request.
        vecs.push_back(mk(1, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 5'd0, 1, i, (i + 1) % 16, tg(i + 1), i == 15, (i + 1) >= 14, i + 1, 0));
        vecs.push_back(mk(0, 1, 5'd0, 0, 0, 0, 5'd24, 1, 1, 16, 1));
        // Read pointer to binary 4 (Gray 6): release seen after the third edge.
        vecs.push_back(mk(0, 0, 5'd6, 0, 0, 0, 5'd24, 1, 1, 16, 1));
        vecs.push_back(mk(0, 0, 5'd6, 0, 0, 0, 5'd24, 1, 1, 16, 1));
        vecs.push_back(mk(0, 0, 5'd6, 0, 0, 0, 5'd24, 0, 0, 12, 1));
        // Read pointer to binary 7 (Gray 4): level 9, overflow still sticky.
        vecs.push_back(mk(0, 0, 5'd4, 0, 0, 0, 5'd24, 0, 0, 12, 1));
        vecs.push_back(mk(0, 0, 5'd4, 0, 0, 0, 5'd24, 0, 0, 12, 1));
        vecs.push_back(mk(0, 0, 5'd4, 0, 0, 0, 5'd24, 0, 0, 9, 1));
        vecs.push_back(mk(1, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5'd0, 1, 0, 1, 5'd1, 0, 0, 1, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].clear, vecs[k].wr, vecs[k].rd);
            #1;
            chk($sformatf("v%0d wr_en", k), 32'(wr_en), 32'(vecs[k].en));
            chk($sformatf("v%0d addr_pre", k), 32'(wr_addr), 32'(vecs[k].addr_pre));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d addr", k), 32'(wr_addr), 32'(vecs[k].addr));
            chk($sformatf("v%0d wgray", k), 32'(wr_gray), 32'(vecs[k].wgray));
            chk($sformatf("v%0d full", k), 32'(full), 32'(vecs[k].full));
            chk($sformatf("v%0d af", k), 32'(af), 32'(vecs[k].af));
            chk($sformatf("v%0d level", k), 32'(level), 32'(vecs[k].level));
            chk($sformatf("v%0d ovf", k), 32'(ovf), 32'(vecs[k].ovf));
        end

        // Wrap: 40 writes with the read pointer trailing by 8.
        do_clear();
        for (int n = 0; n < 40; n++) begin
            drive(1'b0, 1'b1, tg(n >= 8 ? n - 8 : 0));
            #1;
            chk($sformatf("wrap%0d wr_en", n), 32'(wr_en), 32'd1);
            chk($sformatf("wrap%0d addr", n), 32'(wr_addr), 32'(n % 16));
            prev_gray = wr_gray;
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d gray_step", n), 32'($countones(wr_gray ^ prev_gray)), 32'd1);
            chk($sformatf("wrap%0d gray_msb", n), 32'(wr_gray[4]), 32'(((n + 1) >> 4) & 1));
            chk($sformatf("wrap%0d full", n), 32'(full), 32'd0);
        end

        // Almost-full rises only after the 14th accept.
        do_clear();
        for (int n = 1; n <= 14; n++) begin
            drive(1'b0, 1'b1, 5'd0);
            @(posedge clk);
            #1;
            chk($sformatf("af_acc%0d", n), 32'(af), 32'(n >= 14));
        end
        drive(1'b0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        chk("af_hold", 32'(af), 32'd1);
        chk("af_level", 32'(level), 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
